// File: rtl/i2f_rr_arbiter.sv
// i2f_rr_arbiter: round-robin arbiter and sequencer that shares a single
// multi-cycle fixed-point-to-bfloat16 converter between N_REQ requesters.
// One conversion is in flight at a time: IDLE -> LAUNCH -> WAIT -> RESP.
// Optional feature macro: I2F_ARB_TIMEOUT_EN bounds WAIT to TIMEOUT+1 cycles
// and reports expiry on resp_err_o with zero data; when undefined WAIT waits
// indefinitely and resp_err_o is tied low.
module i2f_rr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 7,
    parameter int EXP_WIDTH  = 8,
    parameter int MAN_WIDTH  = 7,
    parameter int TIMEOUT    = 63
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid_i,
    input  logic [N_REQ*INT_WIDTH-1:0]        req_int_i,
    input  logic [N_REQ*FRAC_WIDTH-1:0]       req_frac_i,
    output logic [N_REQ-1:0]                  req_grant_o,
    output logic [N_REQ-1:0]                  resp_valid_o,
    output logic [EXP_WIDTH+MAN_WIDTH:0]      resp_data_o,
    output logic                              resp_err_o,
    output logic                              busy_o,
    output logic                              conv_valid_o,
    output logic [INT_WIDTH-1:0]              conv_int_o,
    output logic [FRAC_WIDTH-1:0]             conv_frac_o,
    input  logic                              conv_valid_i,
    input  logic                              conv_sgn_i,
    input  logic [EXP_WIDTH-1:0]              conv_exp_i,
    input  logic [MAN_WIDTH-1:0]              conv_man_i
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DATA_W = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       lastGrant_q, lastGrant_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [INT_WIDTH-1:0]   convInt_q, convInt_d;
    logic [FRAC_WIDTH-1:0]  convFrac_q, convFrac_d;
    logic [DATA_W-1:0]      respData_q, respData_d;
    logic                   timeoutHit;

    logic                   pickFound;
    logic [IDX_W-1:0]       pickIdx;
    logic [INT_WIDTH-1:0]   pickInt;
    logic [FRAC_WIDTH-1:0]  pickFrac;
    logic [N_REQ-1:0]       ownerOneHot;

    // Rotating priority search: first pass covers indices above the last grant, second pass wraps to the rest.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        pickInt   = '0;
        pickFrac  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pickFound && req_valid_i[i] && (IDX_W'(i) > lastGrant_q)) begin
                pickFound = 1'b1;
                pickIdx   = IDX_W'(i);
                pickInt   = req_int_i[i*INT_WIDTH +: INT_WIDTH];
                pickFrac  = req_frac_i[i*FRAC_WIDTH +: FRAC_WIDTH];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!pickFound && req_valid_i[i] && (IDX_W'(i) <= lastGrant_q)) begin
                pickFound = 1'b1;
                pickIdx   = IDX_W'(i);
                pickInt   = req_int_i[i*INT_WIDTH +: INT_WIDTH];
                pickFrac  = req_frac_i[i*FRAC_WIDTH +: FRAC_WIDTH];
            end
        end
    end

    // Sequencer next state: requests only matter in IDLE, converter results only in WAIT.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        owner_d     = owner_q;
        convInt_d   = convInt_q;
        convFrac_d  = convFrac_q;
        respData_d  = respData_q;
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    owner_d    = pickIdx;
                    convInt_d  = pickInt;
                    convFrac_d = pickFrac;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (conv_valid_i) begin
                    respData_d = {conv_sgn_i, conv_exp_i, conv_man_i};
                    state_d    = RESP;
                end else if (timeoutHit) begin
                    respData_d = '0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                lastGrant_d = owner_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset leaves requester 0 with first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= LAST_IDX;
            owner_q     <= '0;
            convInt_q   <= '0;
            convFrac_q  <= '0;
            respData_q  <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            owner_q     <= owner_d;
            convInt_q   <= convInt_d;
            convFrac_q  <= convFrac_d;
            respData_q  <= respData_d;
        end
    end

`ifdef I2F_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic             respErr_q, respErr_d;

    assign timeoutHit = (waitCnt_q == CNT_LAST);

    // WAIT watchdog: counter restarts on the way into WAIT; a result on the terminal cycle still wins.
    always_comb begin
        waitCnt_d = waitCnt_q;
        respErr_d = respErr_q;
        if (state_q == LAUNCH) begin
            waitCnt_d = '0;
        end else if (state_q == WAIT) begin
            waitCnt_d = waitCnt_q + CNT_W'(1);
            if (conv_valid_i) begin
                respErr_d = 1'b0;
            end else if (timeoutHit) begin
                respErr_d = 1'b1;
            end
        end
    end

    // Watchdog counter and error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt_q <= '0;
            respErr_q <= 1'b0;
        end else begin
            waitCnt_q <= waitCnt_d;
            respErr_q <= respErr_d;
        end
    end

    assign resp_err_o = respErr_q;
`else
    assign timeoutHit = 1'b0;
    assign resp_err_o = 1'b0;
`endif

    assign ownerOneHot  = N_REQ'(1) << owner_q;
    assign req_grant_o  = (state_q == LAUNCH) ? ownerOneHot : '0;
    assign resp_valid_o = (state_q == RESP) ? ownerOneHot : '0;
    assign conv_valid_o = (state_q == LAUNCH);
    assign busy_o       = (state_q != IDLE);
    assign conv_int_o   = convInt_q;
    assign conv_frac_o  = convFrac_q;
    assign resp_data_o  = respData_q;

endmodule

// File: doc/i2f_rr_arbiter.md
# i2f_rr_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle fixed-point-to-bfloat16 converter (`i2f`) between `N_REQ` requesters. It accepts one operand at a time (`INT_WIDTH`-bit two's-complement integer part plus `FRAC_WIDTH`-bit fraction) and launches it into the converter with a single-cycle valid pulse. It then waits for the converter's done pulse and returns the packed bfloat16 result to the requester that owns the operation. It sits between the log-datapath front ends and the single shared converter instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `INT_WIDTH`, 8, integer-part width
- `FRAC_WIDTH`, 7, fraction width
- `EXP_WIDTH`, 8, bfloat16 exponent width
- `MAN_WIDTH`, 7, bfloat16 mantissa width
- `TIMEOUT`, 63, WAIT-state cycle limit (only used with `I2F_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid_i`  in  N_REQ  per-requester request; held high until that requester's grant
- `req_int_i`  in  N_REQ*INT_WIDTH  requester k operand at `[k*INT_WIDTH +: INT_WIDTH]`
- `req_frac_i`  in  N_REQ*FRAC_WIDTH  requester k fraction at `[k*FRAC_WIDTH +: FRAC_WIDTH]`
- `req_grant_o`  out  N_REQ  one-hot, one-cycle pulse: request accepted
- `resp_valid_o`  out  N_REQ  one-hot, one-cycle pulse to the owner
- `resp_data_o`  out  1+EXP_WIDTH+MAN_WIDTH  `{sgn, exp, man}`; valid while `resp_valid_o` is nonzero
- `resp_err_o`  out  1  timeout flag, qualified by `resp_valid_o`
- `busy_o`  out  1  high in every state except IDLE
- `conv_valid_o`  out  1  one-cycle launch pulse to the converter
- `conv_int_o`  out  INT_WIDTH  operand to the converter; held from LAUNCH until the next launch
- `conv_frac_o`  out  FRAC_WIDTH  fraction to the converter; held from LAUNCH until the next launch
- `conv_valid_i`  in  1  converter done pulse
- `conv_sgn_i`, `conv_exp_i`, `conv_man_i`  in  1/EXP_WIDTH/MAN_WIDTH  converter result, sampled on `conv_valid_i`

## Operation
- State register encoding: IDLE, LAUNCH, WAIT, RESP. All outputs are registered or decoded from state only.
- **IDLE:** if any `req_valid_i` bit is set, select the first set bit searching from `(last_grant+1) mod N_REQ` upward with wrap-around.
  - Latch that requester's operand into `conv_int_o`/`conv_frac_o`.
  - Set `owner` to the selected index and go to LAUNCH.
  - If no bit is set, stay in IDLE.
- **LAUNCH (1 cycle):** `conv_valid_o`=1 and `req_grant_o[owner]`=1, then go to WAIT.
- **WAIT:** on `conv_valid_i`, capture `{conv_sgn_i, conv_exp_i, conv_man_i}` into `resp_data_o`, clear `resp_err_o`, and go to RESP.
- **RESP (1 cycle):** `resp_valid_o[owner]`=1, set `last_grant`=`owner`, then go to IDLE.
- `req_valid_i` is ignored outside IDLE. The requester deasserts (or changes operand) after sampling its grant. A still-high request re-arbitrates in the next IDLE.
- `conv_valid_i` is ignored outside WAIT, so stray or late converter pulses are dropped.
- Only one conversion is in flight at a time. `conv_valid_o` is never asserted while the converter is busy.
- No arithmetic is done on the result; fields pass through unchanged. Operand values are not checked.

## Timing
- Reset values:
  - State IDLE, `last_grant`=N_REQ-1 (requester 0 has first priority), `owner`=0.
  - `req_grant_o`=0, `resp_valid_o`=0, `resp_data_o`=0, `resp_err_o`=0, `busy_o`=0, `conv_valid_o`=0, `conv_int_o`=0, `conv_frac_o`=0.
- Request seen in IDLE at cycle 0:
  - Grant and launch in cycle 1.
  - WAIT from cycle 2.
  - If `conv_valid_i` arrives in cycle 2+L, the response pulse is in cycle 3+L.
- Back-to-back: the next selection happens in the IDLE cycle after RESP. Period is L+4 cycles per conversion.
- Reset mid-operation aborts immediately to the reset values. The in-flight converter result is then ignored by the IDLE state.

## Configuration
- `I2F_ARB_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it equals `TIMEOUT` with no `conv_valid_i` (WAIT has lasted TIMEOUT+1 cycles), go to RESP with `resp_err_o`=1 and `resp_data_o`=0.
  - If `conv_valid_i` arrives on the terminal-count cycle, the result wins and `resp_err_o`=0.
- Not defined: no counter is built, WAIT waits indefinitely, and `resp_err_o` is tied to 0.

## Test plan
- **Single request:** requester 0, int=8'h03, frac=0, converter model L=20 → `req_grant_o`=4'b0001 in cycle 1, `conv_int_o`=8'h03, `resp_data_o`=16'h4040, `resp_valid_o`=4'b0001 in cycle 23.
- **Negative operand:** requester 1, int=8'hFE (-2) → `resp_data_o`=16'hC000 delivered to requester 1 only.
- **All four held high from reset:** grants in order 0,1,2,3,0, each grant L+4 cycles after the previous one.
- **Fairness:** after requester 1 is served (`last_grant`=1), requesters 0 and 3 request together → 3 is granted first, then 0.
- **Timeout (macro on, TIMEOUT=63):** converter never responds → `resp_valid_o[owner]` pulses in cycle 66 with `resp_err_o`=1 and data 0. A `conv_valid_i` pulse arriving later is ignored.
- **Reset asserted in WAIT:** all outputs return to 0. A later `conv_valid_i` produces no response. The next simultaneous requests 0 and 2 → 0 is granted first.
